// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-port round-robin sequencer for a shared combinational barrel shifter
// Ports: req0_*/req1_* valid/ready request handshakes (operand, amount, op code);
//        bs_a/bs_op1/bs_op2 registered shifter operands, bs_y shifter result;
//        rsp_valid/rsp_ready response handshake carrying rsp_id and rsp_data.
module shifter_arbiter #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_amt,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] bs_a,
  output logic [SHW-1:0]   bs_op1,
  output logic [1:0]       bs_op2,
  input  logic [WIDTH-1:0] bs_y,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t state;
  logic last_grant, settle, sel0, sel1;
  // On contention the requester not granted last wins; a lone valid always wins.
  always_comb begin
    sel0 = req0_valid & (~req1_valid | last_grant);
    sel1 = req1_valid & (~req0_valid | ~last_grant);
  end
  assign req0_ready = (state == IDLE) & sel0;
  assign req1_ready = (state == IDLE) & sel1;
  // SHIFT spans two edges: bs_* stay settled on the shifter inputs for one full
  // cycle before bs_y is sampled, giving four cycles between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      settle     <= 1'b0;
      bs_a       <= '0;
      bs_op1     <= '0;
      bs_op2     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: if (req0_ready | req1_ready) begin
          bs_a       <= req1_ready ? req1_a : req0_a;
          bs_op1     <= req1_ready ? req1_amt : req0_amt;
          bs_op2     <= req1_ready ? req1_op : req0_op;
          rsp_id     <= req1_ready;
          last_grant <= req1_ready;
          settle     <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: if (settle) begin
          rsp_data  <= bs_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          settle <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter: directed scoreboard bench for shifter_arbiter
module tb_shifter_arbiter;
  localparam int W = 16;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req1_a, bs_a, bs_y, rsp_data;
  logic [S-1:0] req0_amt, req1_amt, bs_op1;
  logic [1:0] req0_op, req1_op, bs_op2;
  logic rsp_valid, rsp_id, rsp_ready;
  typedef struct packed {logic id; logic [W-1:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(.WIDTH(W), .SHW(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_amt(req1_amt), .req1_op(req1_op),
    .bs_a(bs_a), .bs_op1(bs_op1), .bs_op2(bs_op2), .bs_y(bs_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  // Reference shifter: 00 shl, 01 lshr, 10 ashr, 11 rotate right.
  function automatic logic [W-1:0] shf(input logic [W-1:0] a, input logic [S-1:0] n, input logic [1:0] op);
    case (op)
      2'b00: return a << n;
      2'b01: return a >> n;
      2'b10: return $signed(a) >>> n;
      default: return (a >> n) | (a << (W - int'(n)));
    endcase
  endfunction

  assign bs_y = shf(bs_a, bs_op1, bs_op2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go0(input logic [W-1:0] a, input logic [S-1:0] n, input logic [1:0] op);
    req0_valid = 1'b1; req0_a = a; req0_amt = n; req0_op = op;
  endtask

  task automatic go1(input logic [W-1:0] a, input logic [S-1:0] n, input logic [1:0] op);
    req1_valid = 1'b1; req1_a = a; req1_amt = n; req1_op = op;
  endtask

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) q.push_back(exp_t'({1'b0, shf(req0_a, req0_amt, req0_op)}));
      if (req1_valid && req1_ready) q.push_back(exp_t'({1'b1, shf(req1_a, req1_amt, req1_op)}));
      if (rsp_valid && rsp_ready) begin
        chk("sb_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_amt = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_amt = '0; req1_op = '0;
    tick; tick;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_bs_a", 32'(bs_a), 32'd0);
    chk("rst_bs_op1", 32'(bs_op1), 32'd0);
    chk("rst_bs_op2", 32'(bs_op2), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    // Contention and fairness: both valid from reset release for four transactions.
    go0(16'h1111, 4'd2, 2'b01);
    go1(16'h8001, 4'd1, 2'b11);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("fair_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("fair_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
      tick;
      chk("fair_bs_a", 32'(bs_a), (k % 2 == 1) ? 32'h8001 : 32'h1111);
      chk("fair_bs_op1", 32'(bs_op1), (k % 2 == 1) ? 32'd1 : 32'd2);
      chk("fair_bs_op2", 32'(bs_op2), (k % 2 == 1) ? 32'd3 : 32'd1);
      tick; tick;
      chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("fair_rsp_id", 32'(rsp_id), 32'(k % 2));
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    // Single request timing.
    go0(16'hF0F0, 4'd4, 2'b00);
    #1;
    chk("single_rdy0", 32'(req0_ready), 32'd1);
    chk("single_rdy1", 32'(req1_ready), 32'd0);
    tick;
    req0_valid = 1'b0;
    chk("single_bs_a", 32'(bs_a), 32'hF0F0);
    chk("single_bs_op1", 32'(bs_op1), 32'd4);
    chk("single_bs_op2", 32'(bs_op2), 32'd0);
    chk("single_n0_valid", 32'(rsp_valid), 32'd0);
    tick;
    chk("single_n1_bs_a", 32'(bs_a), 32'hF0F0);
    chk("single_n1_valid", 32'(rsp_valid), 32'd0);
    tick;
    chk("single_n2_valid", 32'(rsp_valid), 32'd1);
    chk("single_n2_id", 32'(rsp_id), 32'd0);
    chk("single_n2_data", 32'(rsp_data), 32'h0F00);
    tick;
    chk("single_n3_valid", 32'(rsp_valid), 32'd0);
    // Backpressure: rsp_ready low for five RESP cycles while req0 waits.
    rsp_ready = 1'b0;
    go1(16'h1234, 4'd3, 2'b01);
    #1;
    chk("bp_rdy1", 32'(req1_ready), 32'd1);
    tick;
    req1_valid = 1'b0;
    tick; tick;
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    go0(16'h5555, 4'd1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'(shf(16'h1234, 4'd3, 2'b01)));
      chk("bp_hold_rdy0", 32'(req0_ready), 32'd0);
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    // Reset during SHIFT, then release with only req1 valid.
    go0(16'hABCD, 4'd5, 2'b10);
    tick;
    req0_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rsh_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rsh_rsp_data", 32'(rsp_data), 32'd0);
    chk("rsh_bs_a", 32'(bs_a), 32'd0);
    chk("rsh_bs_op1", 32'(bs_op1), 32'd0);
    chk("rsh_bs_op2", 32'(bs_op2), 32'd0);
    tick;
    go1(16'h00FF, 4'd7, 2'b11);
    rst = 1'b0;
    #1;
    chk("rsh_rdy1", 32'(req1_ready), 32'd1);
    tick;
    req1_valid = 1'b0;
    chk("rsh_bs_a_after", 32'(bs_a), 32'h00FF);
    tick; tick;
    chk("rsh_rsp_valid_after", 32'(rsp_valid), 32'd1);
    chk("rsh_rsp_id_after", 32'(rsp_id), 32'd1);
    tick;
    // Reset during RESP after a req0 grant; contention afterwards must favour req0.
    go0(16'h0F0F, 4'd2, 2'b01);
    tick;
    req0_valid = 1'b0;
    tick; tick;
    chk("rrs_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rrs_rsp_valid_rst", 32'(rsp_valid), 32'd0);
    chk("rrs_rsp_data_rst", 32'(rsp_data), 32'd0);
    chk("rrs_bs_a_rst", 32'(bs_a), 32'd0);
    tick;
    go0(16'h3C3C, 4'd1, 2'b00);
    go1(16'hC3C3, 4'd2, 2'b10);
    rst = 1'b0;
    #1;
    chk("rrs_rdy0", 32'(req0_ready), 32'd1);
    chk("rrs_rdy1", 32'(req1_ready), 32'd0);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rrs_bs_a", 32'(bs_a), 32'h3C3C);
    tick; tick;
    chk("rrs_rsp_id", 32'(rsp_id), 32'd0);
    tick;
    // Amount sweep over every op code.
    for (int op = 0; op < 4; op++) begin
      for (int n = 0; n < 16; n++) begin
        go0(16'hF0F0, 4'(n), 2'(op));
        tick;
        req0_valid = 1'b0;
        tick; tick; tick;
      end
    end
    tick;
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/shifter_arbiter.md
# shifter_arbiter

Sequencer and two-port round-robin arbiter for the shared barrel shifter in the datapath. It accepts shift requests from two requesters over valid/ready handshakes and registers the granted operands. It drives the shifter for one dedicated cycle, captures the result, and returns it to the originating requester over a response handshake. The shifter itself stays purely combinational and is instantiated outside this block. This block only sequences access to it.

## Interface
- WIDTH, 16, data width of the shifter operand and result
- SHW, $clog2(WIDTH), width of the shift-amount field
- clk  in  1  sole clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with valid
- req0_a  in  WIDTH  requester 0 operand
- req0_amt  in  SHW  requester 0 shift amount
- req0_op  in  2  requester 0 shift operation code
- req1_valid / req1_ready / req1_a / req1_amt / req1_op: same as above, for requester 1
- bs_a  out  WIDTH  operand to shifter (registered)
- bs_op1  out  SHW  shift amount to shifter (registered)
- bs_op2  out  2  operation to shifter (registered)
- bs_y  in  WIDTH  shifter result
- rsp_valid  out  1  result available
- rsp_id  out  1  requester the result belongs to (0/1)
- rsp_data  out  WIDTH  captured shifter result
- rsp_ready  in  1  consumer accepts the response

## Operation
- States:
  - IDLE: accepts a request.
  - SHIFT: the shifter is driven and its result is captured.
  - RESP: the response is held.
- Grant rule in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last (round-robin).
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- `reqN_ready = (state==IDLE) && grant==N`. The ready signals are combinational and are never both high.
- Accept (valid & ready):
  - Latch a/amt/op into bs_a/bs_op1/bs_op2.
  - Latch the id into rsp_id.
  - Update last_grant.
  - Go to SHIFT.
- SHIFT: capture bs_y into rsp_data and go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_id and rsp_data are stable until `rsp_valid & rsp_ready`, then go to IDLE.
- The op code is forwarded to the shifter unchanged. The block does not interpret it.
- bs_* hold their last values outside SHIFT.
- No request is dropped once accepted.
- A requester whose valid falls before ready is not granted and loses nothing.

## Timing
- Reset values:
  - state=IDLE
  - req0_ready/req1_ready reflect IDLE grant (0 with no valid)
  - bs_a=0, bs_op1=0, bs_op2=0
  - rsp_valid=0, rsp_id=0, rsp_data=0
  - last_grant=1
- Accept on edge N. The bs_* operands are valid from N+1. bs_y is sampled on edge N+2, and rsp_valid is high from N+2.
- If rsp_ready is high on the first RESP cycle, the response completes on edge N+3. The next accept is then possible on edge N+4.
- Minimum spacing between accepts is therefore 4 cycles.
- rsp_ready stalled k cycles extends RESP by k cycles. Outputs are unchanged throughout the stall.
- Both valid held continuously: grants alternate 0,1,0,1.
- rsp_ready high while rsp_valid is low: ignored.
- Reset asserted mid-SHIFT or mid-RESP:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight request is discarded.
  - last_grant returns to 1.
- Reset released with valids high: accept on the first rising edge after release.

## Test plan
- Single request, rsp_ready tied high:
  - Stimulus: req0: a=16'hF0F0, amt=4, op=2'b00.
  - Required: req0_ready=1 in the accept cycle; bs_a=F0F0, bs_op1=4, bs_op2=00 from N+1; rsp_valid at N+2 with rsp_id=0 and rsp_data equal to the shifter output for (F0F0,4,00); rsp_valid=0 at N+3.
- Contention:
  - Stimulus: req0 and req1 valid from reset, with req1 a=16'h8001, amt=1, op=2'b11.
  - Required: first grant is 0, second is 1; rsp_id sequence is 0,1; the second response's bs_* are 8001/1/11.
- Fairness:
  - Stimulus: both valid for 4 transactions.
  - Required: rsp_id sequence is 0,1,0,1; the ready signals are never both high.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles in RESP.
  - Required: rsp_valid, rsp_id and rsp_data stay constant; no ready is asserted; the transaction completes the cycle rsp_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst during SHIFT, between edges.
  - Required: rsp_valid=0 and bs_*=0 immediately; after release with req1 valid, req1 is accepted on the first edge.
- Amount sweep:
  - Stimulus: req0 with a=F0F0, amt=0..15, each op 00..11.
  - Required: every rsp_data equals the shifter output for the same operands.
